// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQ requesters.
// Latches the winner's payload/mode, pulses t_start and tracks completion via cs.
module spi_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned SZW       = $clog2(REG_WIDTH) + 1,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                           sys_clk,
  input  logic                           rstn,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*REG_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ*SZW-1:0]         req_size,
  input  logic [NUM_REQ-1:0]             req_cpol,
  input  logic [NUM_REQ-1:0]             req_cpha,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic [NUM_REQ-1:0]             err,
  output logic                           busy,
  output logic                           t_start,
  output logic [REG_WIDTH-1:0]           data_in,
  output logic [SZW-1:0]                 t_size,
  output logic                           cpol,
  output logic                           cpha,
  input  logic                           spi_cs
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_START, S_WAIT_LO, S_WAIT_HI, S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d, idx_q, idx_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d, done_q, done_d, err_q, err_d;
  logic                   busy_q, busy_d, t_start_q, t_start_d;
  logic [REG_WIDTH-1:0]   data_q, data_d;
  logic [SZW-1:0]         size_q, size_d;
  logic                   cpol_q, cpol_d, cpha_q, cpha_d;

  logic                   win_found;
  logic [IW-1:0]          win_idx;
  logic                   size_ok;
  int                     cand;

  // First requester at or above the pointer, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= int'(NUM_REQ)) cand = cand - int'(NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  assign size_ok = (size_q != '0) && (size_q <= SZW'(REG_WIDTH));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    data_d    = data_q;
    size_d    = size_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    t_start_d = 1'b0;
    done_d    = '0;
    err_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (win_found && spi_cs) begin
          data_d  = req_data[int'(win_idx)*int'(REG_WIDTH) +: REG_WIDTH];
          size_d  = req_size[int'(win_idx)*int'(SZW) +: SZW];
          cpol_d  = req_cpol[win_idx];
          cpha_d  = req_cpha[win_idx];
          grant_d = NUM_REQ'(1) << win_idx;
          idx_d   = win_idx;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
      // One settle cycle so the SPI idle clock level follows the new cpol.
      S_SETUP: begin
        if (size_ok) begin
          t_start_d = 1'b1;
          state_d   = S_START;
        end else begin
          err_d   = grant_q;
          state_d = S_DONE;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!spi_cs) begin
          cnt_d   = '0;
          state_d = S_WAIT_HI;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = grant_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_HI: begin
        if (spi_cs) begin
          done_d  = grant_q;
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = grant_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        ptr_d   = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + IW'(1);
        cnt_d   = '0;
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      err_q     <= '0;
      busy_q    <= 1'b0;
      t_start_q <= 1'b0;
      data_q    <= '0;
      size_q    <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      t_start_q <= t_start_d;
      data_q    <= data_d;
      size_q    <= size_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign t_start = t_start_q;
  assign data_in = data_q;
  assign t_size  = size_q;
  assign cpol    = cpol_q;
  assign cpha    = cpha_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: vector table plus hand sequences, with a loopback
// SPI master model and a scoreboard of expected grants/completions.
module tb_spi_arbiter;
  localparam int NR = 4;
  localparam int RW = 32;
  localparam int SW = 6;
  localparam int TO = 1024;

  logic              sys_clk = 1'b0;
  logic              rstn;
  logic [NR-1:0]     req;
  logic [NR*RW-1:0]  req_data;
  logic [NR*SW-1:0]  req_size;
  logic [NR-1:0]     req_cpol, req_cpha;
  logic [NR-1:0]     grant, done, err;
  logic              busy, t_start, cpol, cpha, spi_cs;
  logic [RW-1:0]     data_in;
  logic [SW-1:0]     t_size;

  spi_arbiter #(.NUM_REQ(NR), .REG_WIDTH(RW), .SZW(SW), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .rstn(rstn), .req(req), .req_data(req_data),
    .req_size(req_size), .req_cpol(req_cpol), .req_cpha(req_cpha),
    .grant(grant), .done(done), .err(err), .busy(busy), .t_start(t_start),
    .data_in(data_in), .t_size(t_size), .cpol(cpol), .cpha(cpha), .spi_cs(spi_cs)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int           idx;
    logic [RW-1:0] data;
    logic [SW-1:0] size;
    logic         cpol;
    logic         cpha;
    logic         is_err;
    int           tstarts;
  } exp_t;

  typedef struct {
    int           idx;
    logic [RW-1:0] data;
    logic [SW-1:0] size;
    logic         cpol;
    logic         cpha;
    logic         is_err;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t tv[6];

  int n_checks = 0, n_errors = 0, n_done_seen = 0;
  int cyc = 0, grant_cyc = 0, tstart_cyc = 0, tstart_cnt = 0, last_done_cyc = 0;
  logic [NR-1:0] grant_prev = '0;
  logic [NR-1:0] oh;
  logic          cpol_prev = 1'b0;
  logic          cs_stuck;

  function automatic logic [RW-1:0] mask(input logic [SW-1:0] s);
    logic [63:0] m;
    m = (64'd1 << s) - 64'd1;
    return m[RW-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Loopback master model: cs falls 2 cycles after t_start, stays low size+1 cycles.
  int            sl_ph, sl_cnt;
  logic [RW-1:0] echo;
  always @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      spi_cs <= 1'b1; sl_ph <= 0; sl_cnt <= 0; echo <= '0;
    end else begin
      case (sl_ph)
        0: if (t_start && !cs_stuck) begin sl_ph <= 1; sl_cnt <= 2; end
        1: if (sl_cnt == 1) begin
             spi_cs <= 1'b0; echo <= data_in & mask(t_size);
             sl_cnt <= int'(t_size) + 1; sl_ph <= 2;
           end else sl_cnt <= sl_cnt - 1;
        default: if (sl_cnt == 1) begin spi_cs <= 1'b1; sl_ph <= 0; end
                 else sl_cnt <= sl_cnt - 1;
      endcase
    end
  end

  // Monitor: checks grants against scoreboard head, pops on done/err.
  always @(negedge sys_clk) begin
    cyc++;
    if (rstn) begin
      if (grant != '0 && grant_prev == '0) begin
        tstart_cnt = 0;
        grant_cyc  = cyc;
        if (sb.size() == 0) chk("unexpected_grant", 64'(grant), 64'd0);
        else begin
          oh = '0; oh[sb[0].idx] = 1'b1;
          chk("grant", 64'(grant), 64'(oh));
          chk("data_in", 64'(data_in), 64'(sb[0].data));
          chk("t_size", 64'(t_size), 64'(sb[0].size));
          chk("mode", 64'({cpol, cpha}), 64'({sb[0].cpol, sb[0].cpha}));
          chk("busy_on_grant", 64'(busy), 64'd1);
        end
      end
      if (t_start) begin
        tstart_cnt++;
        tstart_cyc = cyc;
        chk("t_start_latency", 64'(cyc - grant_cyc), 64'd1);
        if (sb.size() != 0) chk("cpol_before_start", 64'(cpol_prev), 64'(sb[0].cpol));
      end
      if ((done | err) != '0) begin
        last_done_cyc = cyc;
        n_done_seen++;
        if (sb.size() == 0) chk("unexpected_done", 64'({done, err}), 64'd0);
        else begin
          e = sb.pop_front();
          oh = '0; oh[e.idx] = 1'b1;
          chk("done", 64'(done), e.is_err ? 64'd0 : 64'(oh));
          chk("err", 64'(err), e.is_err ? 64'(oh) : 64'd0);
          chk("t_start_count", 64'(tstart_cnt), 64'(e.tstarts));
          if (!e.is_err) chk("echo", 64'(echo), 64'(e.data & mask(e.size)));
        end
      end
    end
    grant_prev = grant;
    cpol_prev  = cpol;
  end

  task automatic set_req(input int i, input logic [RW-1:0] d, input logic [SW-1:0] s,
                         input logic cp, input logic ch);
    req_data[i*RW +: RW] = d;
    req_size[i*SW +: SW] = s;
    req_cpol[i] = cp;
    req_cpha[i] = ch;
  endtask

  task automatic push(input int i, input logic is_err, input int tstarts);
    exp_t x;
    x.idx = i; x.data = req_data[i*RW +: RW]; x.size = req_size[i*SW +: SW];
    x.cpol = req_cpol[i]; x.cpha = req_cpha[i]; x.is_err = is_err; x.tstarts = tstarts;
    sb.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
    #1;
  endtask

  task automatic wait_done(input int target, input int bound, input string name);
    int k = 0;
    while (n_done_seen < target && k < bound) begin tick(1); k++; end
    chk({name, "_completed"}, 64'(n_done_seen >= target), 64'd1);
  endtask

  task automatic do_reset();
    rstn = 1'b0; req = '0;
    tick(3);
    sb.delete();
    rstn = 1'b1;
    tick(1);
  endtask

  initial begin
    int base;
    rstn = 1'b0; req = '0; req_data = '0; req_size = '0;
    req_cpol = '0; req_cpha = '0; cs_stuck = 1'b0;
    tick(3);
    chk("reset_outputs", 64'({grant, done, err, busy, t_start, cpol, cpha, t_size}), 64'd0);
    chk("reset_data_in", 64'(data_in), 64'd0);
    rstn = 1'b1;
    tick(2);

    // Contention from reset: 0 then 2.
    set_req(0, 32'h1111_0000, 6'd8, 1'b0, 1'b0);
    set_req(2, 32'h2222_00AB, 6'd8, 1'b0, 1'b0);
    push(0, 1'b0, 1); push(2, 1'b0, 1);
    base = n_done_seen;
    req = 4'b0101;
    wait_done(base + 2, 400, "contention");
    req = '0;
    tick(2);

    // All four held continuously from reset: 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 32'hA000_0000 | 32'(i * 17), 6'd4, 1'b0, 1'b0);
    push(0, 1'b0, 1); push(1, 1'b0, 1); push(2, 1'b0, 1); push(3, 1'b0, 1); push(0, 1'b0, 1);
    base = n_done_seen;
    req = 4'b1111;
    wait_done(base + 5, 800, "round_robin");
    req = '0;
    tick(2);

    // Single-requester vector table.
    tv[0] = '{0, 32'hDEADBEEF, 6'd32, 1'b0, 1'b0, 1'b0};
    tv[1] = '{1, 32'h0000CDEF, 6'd16, 1'b1, 1'b1, 1'b0};
    tv[2] = '{2, 32'h5555AAAA, 6'd0,  1'b0, 1'b0, 1'b1};
    tv[3] = '{2, 32'h5555AAAA, 6'd33, 1'b1, 1'b0, 1'b1};
    tv[4] = '{3, 32'hA5A50F0F, 6'd8,  1'b0, 1'b1, 1'b0};
    tv[5] = '{0, 32'h12345678, 6'd1,  1'b1, 1'b0, 1'b0};
    for (int v = 0; v < 6; v++) begin
      set_req(tv[v].idx, tv[v].data, tv[v].size, tv[v].cpol, tv[v].cpha);
      push(tv[v].idx, tv[v].is_err, tv[v].is_err ? 0 : 1);
      base = n_done_seen;
      req = '0; req[tv[v].idx] = 1'b1;
      wait_done(base + 1, 300, "vector");
      req = '0;
      tick(1);
      chk("idle_after_vector", 64'({busy, grant}), 64'd0);
    end

    // Timeout in WAIT_LO with cs stuck high.
    cs_stuck = 1'b1;
    set_req(3, 32'h0BAD_0BAD, 6'd8, 1'b0, 1'b0);
    push(3, 1'b1, 1);
    base = n_done_seen;
    req = 4'b1000;
    wait_done(base + 1, TO + 100, "timeout");
    req = '0;
    chk("timeout_latency", 64'(last_done_cyc - tstart_cyc), 64'(TO + 1));
    tick(1);
    chk("busy_after_timeout", 64'(busy), 64'd0);
    cs_stuck = 1'b0;
    set_req(0, 32'hFEED_F00D, 6'd32, 1'b0, 1'b0);
    push(0, 1'b0, 1);
    base = n_done_seen;
    req = 4'b0001;
    wait_done(base + 1, 300, "after_timeout");
    req = '0;
    tick(2);

    // Reset asserted during WAIT_HI.
    set_req(0, 32'hCAFE_BABE, 6'd32, 1'b0, 1'b0);
    push(0, 1'b0, 1);
    req = 4'b0001;
    begin
      int k = 0;
      while (spi_cs && k < 100) begin tick(1); k++; end
      chk("cs_fell", 64'(spi_cs), 64'd0);
    end
    tick(2);
    base = n_done_seen;
    rstn = 1'b0; req = '0;
    #1;
    chk("mid_reset_outputs", 64'({grant, done, err, busy, t_start, cpol, cpha, t_size}), 64'd0);
    chk("mid_reset_data_in", 64'(data_in), 64'd0);
    sb.delete();
    tick(3);
    rstn = 1'b1;
    tick(3);
    chk("no_done_after_reset", 64'(n_done_seen), 64'(base));
    set_req(1, 32'h0000_7777, 6'd16, 1'b0, 1'b0);
    push(1, 1'b0, 1);
    req = 4'b0010;
    wait_done(base + 1, 300, "post_reset");
    req = '0;
    tick(3);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
Shares one spi_top master (REG_WIDTH-bit shift engine) between NUM_REQ requesters. Each requester presents its own payload, transaction size and SPI mode (cpol/cpha). The arbiter grants requesters round-robin, programs the master, issues a single t_start pulse, and tracks completion by watching the master's active-low cs. A per-state timeout prevents a hung transaction from locking the bus.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
REG_WIDTH, 32, payload width; matches spi_top REG_WIDTH
SZW, $clog2(REG_WIDTH)+1, width of each size field
TIMEOUT, 1024, sys_clk cycles allowed in each wait state before abort

Ports:
sys_clk  in  1  system clock; all logic on its rising edge
rstn  in  1  asynchronous active-low reset
req  in  NUM_REQ  level request, one bit per requester
req_data  in  NUM_REQ*REG_WIDTH  payload; requester i occupies bits [i*REG_WIDTH +: REG_WIDTH]
req_size  in  NUM_REQ*SZW  bit count per requester; valid range 1..REG_WIDTH
req_cpol  in  NUM_REQ  clock polarity per requester
req_cpha  in  NUM_REQ  clock phase per requester
grant  out  NUM_REQ  one-hot; high from SETUP through DONE for the granted requester
done  out  NUM_REQ  one-cycle pulse on successful completion
err  out  NUM_REQ  one-cycle pulse on timeout or invalid size
busy  out  1  high in every state except IDLE
t_start  out  1  to spi_top; one-cycle start pulse
data_in  out  REG_WIDTH  to spi_top; latched payload
t_size  out  SZW  to spi_top; latched size
cpol  out  1  to spi_top
cpha  out  1  to spi_top
spi_cs  in  1  from spi_top cs; active low, synchronous to sys_clk

Behaviour:
- Reset (rstn=0, asynchronous): all outputs 0, FSM in IDLE, round-robin pointer 0, timeout counter 0. Reset asserted mid-transaction aborts immediately. No done or err pulse is produced on reset.
- States: IDLE, SETUP, START, WAIT_LO, WAIT_HI, DONE.
- IDLE: arbitrates only when req!=0 and spi_cs==1. The winner is the first set req bit searching from the pointer upward with wrap. On that edge the arbiter:
  - latches req_data/req_size/req_cpol/req_cpha into data_in/t_size/cpol/cpha;
  - sets grant and busy;
  - moves to SETUP.
- Invalid size (0 or >REG_WIDTH): the winner still gets grant for one cycle in SETUP, then err pulses in DONE and t_start is never asserted.
- SETUP: holds for exactly 1 cycle so cpol and the SPI idle clock level settle before the start pulse. Then goes to START, or to DONE with err if the size is invalid.
- START: t_start=1 for exactly this cycle; then WAIT_LO with the counter cleared.
- WAIT_LO: waits for spi_cs==0. WAIT_HI: waits for spi_cs==1.
  - Each wait state clears the counter on entry and increments it every cycle.
  - Counter reaching TIMEOUT moves to DONE with err flagged.
  - Normal exit is WAIT_LO -> WAIT_HI -> DONE.
- DONE (1 cycle): done[i] or err[i] pulses; pointer <= (i+1) mod NUM_REQ; grant and busy clear on exit to IDLE.
- data_in, t_size, cpol and cpha keep their latched values until the next grant. They change only on the IDLE->SETUP edge.
- A requester dropping req after grant is ignored: the transaction completes and done/err still pulse.
- req still held after done means the requester re-enters arbitration at lowest priority.
- Minimum turnaround is done -> next SETUP after 1 IDLE cycle. A new grant requires spi_cs==1.
- Mutual exclusion: grant is always one-hot or zero; at most one done/err bit per transaction.

Test Plan:
- Single transfer: req[0], data 32'hDEADBEEF, size 32, mode 0, with loopback slave -> exactly one t_start, 1 cycle after grant rises; data_in=DEADBEEF; done[0] pulses 1 cycle after cs returns high; slave echo matches DEADBEEF.
- Contention: req[0] and req[2] asserted in the same cycle from reset -> grant order 0 then 2. With all four held continuously -> grant order 0,1,2,3,0; no requester granted twice in a row.
- Mode and size switch: req[1] with cpol=1, cpha=1, size 16, data 32'h0000CDEF -> cpol=1 at least 1 cycle before t_start; t_size=16; done[1]; echoed data 0xCDEF.
- Timeout: spi_cs tied high, req[3] -> t_start pulses, then err[3] after TIMEOUT cycles in WAIT_LO; no done; busy back to 0; the next request is serviced normally.
- Invalid size: req[2] with size 0, then 33 -> err[2] pulse each time, t_start stays 0, cs never asserted.
- Reset mid-transfer: rstn=0 during WAIT_HI -> all outputs 0 in the same cycle, no done/err. After release, req[1] is granted first (pointer at 0, req[1] the only requester).
